// File: rtl/timer_pkg.sv
// Shared register map and control-word layout for the multi-channel J1 timer.
package timer_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd2;
    localparam logic [2:0] OFF_COMPARE = 3'd4;
    localparam logic [2:0] OFF_COUNTER = 3'd6;

    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_AR = 1;
    localparam int unsigned CTRL_IE = 2;

    localparam int unsigned STAT_FLAG  = 0;
    localparam int unsigned STAT_MATCH = 1;

    // Packed so that en/ar/ie land on bits 0/1/2 of the CTRL register.
    typedef struct packed {
        logic ie;
        logic ar;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL, COMPARE, COUNTER and sticky match flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_tick,
    input  logic              i_we_ctrl,
    input  logic              i_we_status,
    input  logic              i_we_compare,
    input  logic              i_we_counter,
    input  logic [DATA_W-1:0] i_wdata,
    output ctrl_t             o_ctrl,
    output logic [WIDTH-1:0]  o_counter,
    output logic [WIDTH-1:0]  o_compare,
    output logic              o_flag,
    output logic              o_match
);

    ctrl_t            r_ctrl;
    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] r_compare;
    logic             r_flag;

    logic [WIDTH-1:0] w_wval;
    logic             w_match;
    logic             w_step;
    logic             w_event;
    logic             w_unused_wdata;

    assign w_wval         = i_wdata[WIDTH-1:0];
    assign w_unused_wdata = ^i_wdata;
    assign w_match        = (r_counter == r_compare);
    assign w_step         = i_tick & r_ctrl.en;
    assign w_event        = w_step & w_match;

    // Bus writes take priority over the tick update; a flag set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl    <= '0;
            r_counter <= '0;
            r_compare <= '1;
            r_flag    <= 1'b0;
        end else begin
            if (i_we_ctrl) begin
                r_ctrl.en <= i_wdata[CTRL_EN];
                r_ctrl.ar <= i_wdata[CTRL_AR];
                r_ctrl.ie <= i_wdata[CTRL_IE];
            end else if (w_event && !r_ctrl.ar) begin
                r_ctrl.en <= 1'b0;
            end

            if (i_we_compare) begin
                r_compare <= w_wval;
            end

            if (i_we_counter) begin
                r_counter <= w_wval;
            end else if (w_step) begin
                if (!w_match) begin
                    r_counter <= r_counter + WIDTH'(1);
                end else if (r_ctrl.ar) begin
                    r_counter <= '0;
                end
            end

            if (w_event) begin
                r_flag <= 1'b1;
            end else if (i_we_status && i_wdata[STAT_FLAG]) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign o_ctrl    = r_ctrl;
    assign o_counter = r_counter;
    assign o_compare = r_compare;
    assign o_flag    = r_flag;
    assign o_match   = w_match;

endmodule

// File: rtl/peripheral_timer_multi.sv
// NCH-channel timer on one J1 I/O slot: shared prescaler, register decode, read mux, irq.
module peripheral_timer_multi
    import timer_pkg::*;
#(
    parameter int unsigned clk_freq = 100000000,
    parameter int unsigned NCH      = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d_in,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] d_out,
    output logic              irq
);

    localparam int unsigned CH_W  = ADDR_W - 3;
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if (clk_freq == 0 || NCH < 1 || NCH > 8 || WIDTH < 1 || WIDTH > 16 ||
        PRESCALE < 1 || ADDR_W < 4 || (2 ** CH_W) < NCH) begin : g_bad_params
        $error("peripheral_timer_multi: illegal parameter combination");
    end

    logic              r_ack;
    logic [DATA_W-1:0] r_dout;
    logic              r_irq;

    logic              w_tick;
    logic [CH_W-1:0]   w_chan;
    logic [2:0]        w_off;
    logic              w_p_rd;
    logic              w_p_wr;
    logic [DATA_W-1:0] w_rdata;

    ctrl_t             w_ctrl    [NCH];
    logic [WIDTH-1:0]  w_counter [NCH];
    logic [WIDTH-1:0]  w_compare [NCH];
    logic [NCH-1:0]    w_flag;
    logic [NCH-1:0]    w_match;
    logic [NCH-1:0]    w_sel;
    logic [NCH-1:0]    w_irq_src;

    // Free-running prescaler; its wrap cycle is the count tick for every channel.
    if (PRESCALE == 1) begin : g_no_pre
        assign w_tick = 1'b1;
    end else begin : g_pre
        logic [PRE_W-1:0] r_pre;
        assign w_tick = (r_pre == PRE_W'(PRESCALE - 1));
        always_ff @(posedge clk) begin
            if (reset || w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

    assign w_chan = addr[ADDR_W-1:3];
    assign w_off  = addr[2:0];
    assign w_p_rd = rd & cs & ~r_ack;
    assign w_p_wr = wr & cs & ~r_ack & ~rd;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_sel[i]     = (w_chan == CH_W'(i));
        assign w_irq_src[i] = w_flag[i] & w_ctrl[i].ie;

        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .i_tick       (w_tick),
            .i_we_ctrl    (w_p_wr & w_sel[i] & (w_off == OFF_CTRL)),
            .i_we_status  (w_p_wr & w_sel[i] & (w_off == OFF_STATUS)),
            .i_we_compare (w_p_wr & w_sel[i] & (w_off == OFF_COMPARE)),
            .i_we_counter (w_p_wr & w_sel[i] & (w_off == OFF_COUNTER)),
            .i_wdata      (d_in),
            .o_ctrl       (w_ctrl[i]),
            .o_counter    (w_counter[i]),
            .o_compare    (w_compare[i]),
            .o_flag       (w_flag[i]),
            .o_match      (w_match[i])
        );
    end

    // Unselected channels, odd offsets and channels beyond NCH all read as zero.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_sel[i]) begin
                case (w_off)
                    OFF_CTRL:    w_rdata = DATA_W'(w_ctrl[i]);
                    OFF_STATUS:  w_rdata = DATA_W'({w_match[i], w_flag[i]});
                    OFF_COMPARE: w_rdata = DATA_W'(w_compare[i]);
                    OFF_COUNTER: w_rdata = DATA_W'(w_counter[i]);
                    default:     w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack  <= 1'b0;
            r_dout <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_ack <= w_p_rd | w_p_wr;
            if (w_p_rd) begin
                r_dout <= w_rdata;
            end
            r_irq <= |w_irq_src;
        end
    end

    assign d_out = r_dout;
    assign irq   = r_irq;

endmodule

// File: tb/tb_peripheral_timer_multi.sv
// Scoreboard bench: two builds (PRESCALE=1/NCH=3 and PRESCALE=4/NCH=2) on a shared bus.
module tb_peripheral_timer_multi;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] d_in;
    logic        cs_a, cs_b;
    logic [5:0]  addr;
    logic        rd, wr;
    logic [15:0] d_out_a, d_out_b;
    logic        irq_a, irq_b;

    always #5 clk = ~clk;

    peripheral_timer_multi #(
        .clk_freq(100000000), .NCH(3), .WIDTH(16), .PRESCALE(1), .ADDR_W(6)
    ) u_dut_a (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs_a), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out_a), .irq(irq_a)
    );

    peripheral_timer_multi #(
        .clk_freq(100000000), .NCH(2), .WIDTH(16), .PRESCALE(4), .ADDR_W(6)
    ) u_dut_b (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs_b), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out_b), .irq(irq_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int wr_edge  = 0;
    int rst_cyc  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side handshake model: which posedges accept a read on each instance.
    logic m_ack_a = 1'b0, m_ack_b = 1'b0, fire_a = 1'b0, fire_b = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            m_ack_a <= 1'b0; m_ack_b <= 1'b0; fire_a <= 1'b0; fire_b <= 1'b0;
        end else begin
            m_ack_a <= cs_a & (rd | wr) & ~m_ack_a;
            m_ack_b <= cs_b & (rd | wr) & ~m_ack_b;
            fire_a  <= cs_a & rd & ~m_ack_a;
            fire_b  <= cs_b & rd & ~m_ack_b;
        end
    end

    logic [15:0] q_val[$];
    string       q_tag[$];
    logic [15:0] hold_a = '0, hold_b = '0;
    string       cur_tag;

    // Pop on every accepted read; between reads d_out must hold the last read value.
    always @(negedge clk) begin
        if (reset) begin
            hold_a = '0;
            hold_b = '0;
        end else begin
            cur_tag = "dout_hold";
            if (fire_a || fire_b) begin
                if (q_val.size() == 0) begin
                    check_val("sb_empty", 32'(q_val.size()), 32'd1);
                end else begin
                    cur_tag = q_tag.pop_front();
                    if (fire_a) hold_a = q_val.pop_front();
                    else        hold_b = q_val.pop_front();
                end
            end
            check_val(fire_a ? cur_tag : "dout_hold_a", 32'(d_out_a), 32'(hold_a));
            check_val(fire_b ? cur_tag : "dout_hold_b", 32'(d_out_b), 32'(hold_b));
        end
    end

    task automatic bus_wr(input bit sel, input int ch, input int off, input logic [15:0] data);
        addr = 6'(ch * 8 + off); d_in = data; wr = 1'b1;
        cs_a = !sel; cs_b = sel;
        wr_edge = cyc + 1;
        @(negedge clk);
        wr = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_rd(input bit sel, input int ch, input int off, input logic [15:0] exp,
                          input string tag, input bit also_wr = 1'b0);
        q_val.push_back(exp); q_tag.push_back(tag);
        addr = 6'(ch * 8 + off); d_in = 16'h1234; rd = 1'b1; wr = also_wr;
        cs_a = !sel; cs_b = sel;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
        @(negedge clk);
    endtask

    // rd held for 2*nfire cycles on a running counter whose value after posedge m is (m-ref)%modv.
    task automatic rd_burst(input bit sel, input int ch, input int off, input int nfire,
                            input int ref_cyc, input int modv, input string tag);
        for (int j = 0; j < nfire; j++) begin
            q_val.push_back(16'((cyc + 2 * j - ref_cyc) % modv));
            q_tag.push_back(tag);
        end
        addr = 6'(ch * 8 + off); rd = 1'b1; cs_a = !sel; cs_b = sel;
        repeat (2 * nfire) @(negedge clk);
        rd = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic align(input int ref_cyc, input int modv, input int r);
        while (((cyc - ref_cyc) % modv) != r) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2, c, wb, t3, nt, m;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
        addr = '0; d_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rst_cyc = cyc;
        check_val("rst_irq_a", 32'(irq_a), 32'd0);
        check_val("rst_irq_b", 32'(irq_b), 32'd0);

        for (int ch = 0; ch < 3; ch++) begin
            bus_rd(0, ch, OFF_CTRL,    16'h0000, "rst_ctrl");
            bus_rd(0, ch, OFF_STATUS,  16'h0000, "rst_status");
            bus_rd(0, ch, OFF_COMPARE, 16'hFFFF, "rst_compare");
            bus_rd(0, ch, OFF_COUNTER, 16'h0000, "rst_counter");
        end
        bus_rd(1, 1, OFF_COMPARE, 16'hFFFF, "rst_compare_b");

        // One-shot on ch0.
        bus_wr(0, 0, OFF_COMPARE, 16'd5);
        bus_wr(0, 0, OFF_CTRL, 16'h0001);
        repeat (10) @(negedge clk);
        bus_rd(0, 0, OFF_COUNTER, 16'd5, "os_counter");
        bus_rd(0, 0, OFF_CTRL, 16'h0000, "os_en_cleared");
        bus_rd(0, 0, OFF_STATUS, 16'h0003, "os_status");
        repeat (5) @(negedge clk);
        bus_rd(0, 0, OFF_COUNTER, 16'd5, "os_counter_held");
        bus_wr(0, 0, OFF_STATUS, 16'h0001);
        bus_rd(0, 0, OFF_STATUS, 16'h0002, "os_flag_clr");
        check_val("os_irq", 32'(irq_a), 32'd0);

        // rd and wr together: read happens, write dropped.
        bus_rd(0, 0, OFF_COMPARE, 16'd5, "rdwr_read", 1'b1);
        bus_rd(0, 0, OFF_COMPARE, 16'd5, "rdwr_wr_dropped");

        // Auto-reload with IE on ch1, period 4.
        bus_wr(0, 1, OFF_COMPARE, 16'd3);
        bus_wr(0, 1, OFF_CTRL, 16'h0007);
        w1 = wr_edge;
        while (cyc < w1 + 7) begin
            check_val("ar_irq_rise", 32'(irq_a), 32'(cyc >= w1 + 5));
            @(negedge clk);
        end
        rd_burst(0, 1, OFF_COUNTER, 4, w1, 4, "ar_count");
        align(w1, 4, 0);
        bus_wr(0, 1, OFF_STATUS, 16'h0001);
        c = wr_edge;
        while (cyc < c + 6) begin
            check_val("ar_irq_clr_rerise", 32'(irq_a), 32'(cyc >= c + 4));
            @(negedge clk);
        end
        align(w1, 4, 3);
        bus_wr(0, 1, OFF_STATUS, 16'h0001);
        bus_rd(0, 1, OFF_STATUS, 16'h0001, "clr_vs_event");
        bus_wr(0, 1, OFF_CTRL, 16'h0000);
        bus_wr(0, 1, OFF_STATUS, 16'h0001);
        check_val("ar_irq_off", 32'(irq_a), 32'd0);

        // Free-running ch2: held rd and counter write on a tick.
        bus_wr(0, 2, OFF_CTRL, 16'h0003);
        w2 = wr_edge;
        rd_burst(0, 2, OFF_COUNTER, 3, w2, 65536, "held_rd");
        bus_wr(0, 2, OFF_COUNTER, 16'h0010);
        c = wr_edge;
        rd_burst(0, 2, OFF_COUNTER, 2, c - 16, 65536, "cnt_wr_vs_tick");
        bus_wr(0, 2, OFF_CTRL, 16'h0000);

        // Out-of-range channel and odd offsets.
        bus_wr(0, 3, OFF_CTRL, 16'hFFFF);
        bus_rd(0, 3, OFF_CTRL, 16'h0000, "oor_ctrl");
        bus_rd(0, 3, OFF_COMPARE, 16'h0000, "oor_compare");
        bus_rd(0, 0, OFF_CTRL, 16'h0000, "oor_ch0_ctrl");
        bus_rd(0, 1, OFF_CTRL, 16'h0000, "oor_ch1_ctrl");
        bus_rd(0, 2, OFF_CTRL, 16'h0000, "oor_ch2_ctrl");
        bus_rd(0, 1, OFF_COMPARE, 16'd3, "oor_ch1_compare");
        bus_wr(0, 0, 1, 16'hFFFF);
        bus_rd(0, 0, 1, 16'h0000, "odd_off1");
        bus_rd(0, 0, 7, 16'h0000, "odd_off7");
        bus_rd(0, 0, OFF_CTRL, 16'h0000, "odd_ch0_ctrl");
        check_val("oor_irq", 32'(irq_a), 32'd0);

        // PRESCALE=4 build: event on the third tick after enable.
        bus_wr(1, 0, OFF_COMPARE, 16'd2);
        bus_wr(1, 0, OFF_CTRL, 16'h0005);
        wb = wr_edge;
        nt = 0; m = wb;
        while (nt < 3) begin
            m++;
            if (((m - 1 - rst_cyc) % 4) == 3) nt++;
        end
        t3 = m;
        while (cyc < wb + 15) begin
            check_val("ps_irq", 32'(irq_b), 32'(cyc >= t3 + 1));
            @(negedge clk);
        end
        bus_rd(1, 0, OFF_COUNTER, 16'd2, "ps_counter");
        bus_rd(1, 0, OFF_CTRL, 16'h0004, "ps_ctrl");
        bus_rd(1, 0, OFF_STATUS, 16'h0003, "ps_status");

        // Reset in the middle of a running count.
        bus_wr(0, 1, OFF_CTRL, 16'h0007);
        repeat (6) @(negedge clk);
        check_val("pre_rst_irq", 32'(irq_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_irq", 32'(irq_a), 32'd0);
        check_val("mid_rst_dout", 32'(d_out_a), 32'd0);
        reset = 1'b0;
        bus_rd(0, 1, OFF_CTRL, 16'h0000, "mid_rst_ctrl");
        bus_rd(0, 1, OFF_COUNTER, 16'h0000, "mid_rst_counter");
        bus_rd(0, 1, OFF_COMPARE, 16'hFFFF, "mid_rst_compare");

        repeat (2) @(negedge clk);
        check_val("sb_drain", 32'(q_val.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
